// File: rtl/pc_decode_unit_pkg.sv
// Shared definitions for the PC / instruction-decode slice.
// Holds the addressing-mode encodings, ALU opcode constants, the
// instruction-class field values (instruction[27:25]) and the packed
// decode bundle passed from instr_decoder to the top.
package pc_decode_unit_pkg;

  // Addressing modes.
  localparam logic [1:0] AM_IMM    = 2'b00;  // rotated 32-bit immediate (data processing)
  localparam logic [1:0] AM_SHREG  = 2'b01;  // shifted register (data processing)
  localparam logic [1:0] AM_LS_IMM = 2'b10;  // 12-bit immediate offset (load/store)
  localparam logic [1:0] AM_LS_REG = 2'b11;  // register offset (load/store)

  // ALU opcodes (A32 data-processing opcode field).
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_TST = 4'b1000;
  localparam logic [3:0] ALU_TEQ = 4'b1001;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_CMN = 4'b1011;

  // Instruction classes, instruction[27:25].
  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LS_IMM = 3'b010;
  localparam logic [2:0] CLS_LS_REG = 3'b011;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  typedef struct packed {
    logic [1:0] am;
    logic       rf_en;
    logic [3:0] alu_op;
    logic       load;
    logic       branch_link;
    logic       s_bit;
    logic       rw;
    logic       size;
    logic       datamem_en;
  } decode_t;

  // TST/TEQ/CMP/CMN only set flags; they never write the register file.
  function automatic logic is_compare(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational A32-style instruction decoder.
// Ports:
//   instr_i  32-bit instruction word
//   dec_o    decode bundle (am, rf_en, alu_op, load, branch_link, s_bit, rw, size, datamem_en)
// The condition field [31:28] is ignored. An all-zero body ([27:0]==0) is a NOP
// and decodes to all zeros, even though it would otherwise look like AND.
module instr_decoder
  import pc_decode_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  output decode_t     dec_o
);

  logic [2:0] cls;
  logic       unused_cond;

  assign cls         = instr_i[27:25];
  assign unused_cond = ^instr_i[31:28];

  always_comb begin
    dec_o = '0;
    if (instr_i[27:0] != 28'd0) begin
      unique case (cls)
        CLS_DP_REG, CLS_DP_IMM: begin
          dec_o.am     = (cls == CLS_DP_IMM) ? AM_IMM : AM_SHREG;
          dec_o.alu_op = instr_i[24:21];
          dec_o.s_bit  = instr_i[20];
          dec_o.rf_en  = ~is_compare(instr_i[24:21]);
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          dec_o.am         = (cls == CLS_LS_IMM) ? AM_LS_IMM : AM_LS_REG;
          dec_o.datamem_en = 1'b1;
          dec_o.load       = instr_i[20];
          dec_o.rf_en      = instr_i[20];
          dec_o.rw         = ~instr_i[20];
          dec_o.size       = instr_i[22];
          // U bit selects whether the offset is added to or subtracted from the base.
          dec_o.alu_op     = instr_i[23] ? ALU_ADD : ALU_SUB;
        end
        CLS_BRANCH: begin
          dec_o.branch_link = 1'b1;
          dec_o.rf_en       = instr_i[24];  // BL writes the return address to R14
          dec_o.alu_op      = ALU_ADD;
        end
        default: dec_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/pc_decode_unit.sv
// Program counter with +4 incrementer plus a combinational instruction decoder.
// Ports:
//   clk          rising-edge clock for the PC register
//   reset        asynchronous active-low reset; clears the PC
//   pc_le        PC load enable; 1 = advance PC to pc_next on the clock edge
//   instruction  instruction word to decode
//   pc_out       current PC
//   pc_next      pc_out + 4 (wraps modulo 2^32)
//   am, rf_en, alu_op, load, branch_link, s_bit, rw, size, datamem_en
//                decode outputs, purely combinational from instruction
module pc_decode_unit
  import pc_decode_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_le,
  input  logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_next,
  output logic [1:0]  am,
  output logic        rf_en,
  output logic [3:0]  alu_op,
  output logic        load,
  output logic        branch_link,
  output logic        s_bit,
  output logic        rw,
  output logic        size,
  output logic        datamem_en
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_inc;
  decode_t     dec;

  always_comb begin
    pc_inc = pc_q + 32'd4;
    pc_d   = pc_le ? pc_inc : pc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out  = pc_q;
  assign pc_next = pc_inc;

  instr_decoder u_instr_decoder (
    .instr_i (instruction),
    .dec_o   (dec)
  );

  assign am          = dec.am;
  assign rf_en       = dec.rf_en;
  assign alu_op      = dec.alu_op;
  assign load        = dec.load;
  assign branch_link = dec.branch_link;
  assign s_bit       = dec.s_bit;
  assign rw          = dec.rw;
  assign size        = dec.size;
  assign datamem_en  = dec.datamem_en;

endmodule

// File: tb/tb_pc_decode_unit.sv
module tb_pc_decode_unit;

  logic        clk;
  logic        reset;
  logic        pc_le;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_next;
  logic [1:0]  am;
  logic        rf_en;
  logic [3:0]  alu_op;
  logic        load;
  logic        branch_link;
  logic        s_bit;
  logic        rw;
  logic        size;
  logic        datamem_en;

  int n_checks = 0;
  int n_fail   = 0;

  pc_decode_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_le       (pc_le),
    .instruction (instruction),
    .pc_out      (pc_out),
    .pc_next     (pc_next),
    .am          (am),
    .rf_en       (rf_en),
    .alu_op      (alu_op),
    .load        (load),
    .branch_link (branch_link),
    .s_bit       (s_bit),
    .rw          (rw),
    .size        (size),
    .datamem_en  (datamem_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected decode packed as {am, rf_en, alu_op, load, bl, s, rw, size, dm}.
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [12:0] exp;
  } vec_t;

  function automatic logic [12:0] pk(input logic [1:0] a, input logic rf, input logic [3:0] op,
                                     input logic ld, input logic bl, input logic s,
                                     input logic w, input logic sz, input logic dm);
    return {a, rf, op, ld, bl, s, w, sz, dm};
  endfunction

  function automatic logic [12:0] dec_now();
    return {am, rf_en, alu_op, load, branch_link, s_bit, rw, size, datamem_en};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_dec(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = dec_now();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got am=%b rf=%b alu=%b ld=%b bl=%b s=%b rw=%b sz=%b dm=%b expected am=%b rf=%b alu=%b ld=%b bl=%b s=%b rw=%b sz=%b dm=%b",
               name, act[12:11], act[10], act[9:6], act[5], act[4], act[3], act[2], act[1],
               act[0], exp[12:11], exp[10], exp[9:6], exp[5], exp[4], exp[3], exp[2], exp[1],
               exp[0]);
    end
  endtask

  vec_t vecs [19];

  initial begin
    vecs[0]  = '{"ANDS_imm",  32'hE2110000, pk(2'b00, 1, 4'b0000, 0, 0, 1, 0, 0, 0)};
    vecs[1]  = '{"LDRB_reg",  32'hE7D12000, pk(2'b11, 1, 4'b0100, 1, 0, 0, 0, 1, 1)};
    vecs[2]  = '{"BNE",       32'h1AFFFFFD, pk(2'b00, 0, 4'b0100, 0, 1, 0, 0, 0, 0)};
    vecs[3]  = '{"AND_imm",   32'hE2010000, pk(2'b00, 1, 4'b0000, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{"NOP",       32'h00000000, pk(2'b00, 0, 4'b0000, 0, 0, 0, 0, 0, 0)};
    vecs[5]  = '{"CMP_imm",   32'hE3500000, pk(2'b00, 0, 4'b1010, 0, 0, 1, 0, 0, 0)};
    vecs[6]  = '{"ADD_reg",   32'hE0810002, pk(2'b01, 1, 4'b0100, 0, 0, 0, 0, 0, 0)};
    vecs[7]  = '{"STR_imm",   32'hE5810000, pk(2'b10, 0, 4'b0100, 0, 0, 0, 1, 0, 1)};
    vecs[8]  = '{"LDR_down",  32'hE5110004, pk(2'b10, 1, 4'b0010, 1, 0, 0, 0, 0, 1)};
    vecs[9]  = '{"BL",        32'hEB000000, pk(2'b00, 1, 4'b0100, 0, 1, 0, 0, 0, 0)};
    vecs[10] = '{"cls100",    32'hE8900000, pk(2'b00, 0, 4'b0000, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{"cls111",    32'hEF000000, pk(2'b00, 0, 4'b0000, 0, 0, 0, 0, 0, 0)};
    vecs[12] = '{"ANDS_cond0",32'h02110000, pk(2'b00, 1, 4'b0000, 0, 0, 1, 0, 0, 0)};
    vecs[13] = '{"TST_reg",   32'hE1100001, pk(2'b01, 0, 4'b1000, 0, 0, 1, 0, 0, 0)};
    vecs[14] = '{"MOV_imm",   32'hE3A00001, pk(2'b00, 1, 4'b1101, 0, 0, 0, 0, 0, 0)};
    vecs[15] = '{"STRB_reg",  32'hE7C12003, pk(2'b11, 0, 4'b0100, 0, 0, 0, 1, 1, 1)};
    vecs[16] = '{"CMN_reg",   32'hE1700000, pk(2'b01, 0, 4'b1011, 0, 0, 1, 0, 0, 0)};
    vecs[17] = '{"TEQ_reg",   32'hE1300000, pk(2'b01, 0, 4'b1001, 0, 0, 1, 0, 0, 0)};
    vecs[18] = '{"AND_reg_1", 32'h00000001, pk(2'b01, 1, 4'b0000, 0, 0, 0, 0, 0, 0)};

    // Reset asserted from t0, released at t3.
    reset       = 1'b0;
    pc_le       = 1'b1;
    instruction = 32'h0;
    #1;
    check32("pc_out_reset", pc_out, 32'h0);
    check32("pc_next_reset", pc_next, 32'h4);
    #2 reset = 1'b1;

    @(negedge clk) check32("pc_seq_4", pc_out, 32'd4);
    @(negedge clk) check32("pc_seq_8", pc_out, 32'd8);
    @(negedge clk) check32("pc_seq_12", pc_out, 32'd12);
    check32("pc_next_16", pc_next, 32'd16);

    // Hold for two edges.
    pc_le = 1'b0;
    @(negedge clk) check32("pc_hold_1", pc_out, 32'd12);
    @(negedge clk) check32("pc_hold_2", pc_out, 32'd12);
    pc_le = 1'b1;
    @(negedge clk) check32("pc_resume_16", pc_out, 32'd16);

    // Mid-run asynchronous reset, away from any clock edge.
    #2 reset = 1'b0;
    #1;
    check32("pc_async_reset", pc_out, 32'h0);
    check32("pc_next_async_reset", pc_next, 32'h4);
    @(negedge clk) check32("pc_held_in_reset", pc_out, 32'h0);
    #2 reset = 1'b1;
    @(negedge clk) check32("pc_first_after_reset", pc_out, 32'd4);

    // Wrap at the top of the address space.
    force dut.pc_q = 32'hFFFFFFFC;
    #1;
    check32("pc_preset", pc_out, 32'hFFFFFFFC);
    check32("pc_next_wrap", pc_next, 32'h0);
    release dut.pc_q;
    @(negedge clk) check32("pc_wrap_0", pc_out, 32'h0);
    check32("pc_next_after_wrap", pc_next, 32'h4);

    // Decode does not depend on reset.
    reset       = 1'b0;
    instruction = 32'hE2110000;
    #1;
    check_dec("ANDS_in_reset", pk(2'b00, 1, 4'b0000, 0, 0, 1, 0, 0, 0));
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      instruction = vecs[i].instr;
      #1;
      check_dec(vecs[i].name, vecs[i].exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_decode_unit.md
PC_DECODE_UNIT -- requirements
Module: pc_decode_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for the PC register.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears the PC.
REQ-004 pc_le  input  1  PC load enable; 1 = advance PC on the clock edge.
REQ-005 instruction  input  32  instruction word to decode (ARM-style A32 encoding).
REQ-006 pc_out  output  32  current PC value.
REQ-007 pc_next  output  32  pc_out + 4.
REQ-008 am  output  2  addressing mode.
REQ-009 rf_en  output  1  register-file write enable.
REQ-010 alu_op  output  4  ALU operation.
REQ-011 load  output  1  load instruction (writeback from memory).
REQ-012 branch_link  output  1  branch instruction.
REQ-013 s_bit  output  1  update condition flags.
REQ-014 rw  output  1  memory direction: 0 = read, 1 = write.
REQ-015 size  output  1  memory size: 1 = byte, 0 = word.
REQ-016 datamem_en  output  1  data-memory access enable.

Function
REQ-017 pc_next SHALL equal pc_out + 4, computed combinationally, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-018 On each rising clk edge with reset high and pc_le=1, pc_out SHALL load pc_next.
REQ-019 With pc_le=0, pc_out SHALL hold its value.
REQ-020 Decode outputs SHALL be purely combinational from instruction, with zero latency and independent of clk and reset.
REQ-021 The condition field instruction[31:28] SHALL NOT affect decode.
REQ-022 instruction == 0x00000000 (NOP) SHALL drive every decode output to 0.
REQ-023 AM encodings SHALL be:
- 00 = rotated 32-bit immediate (data processing).
- 01 = shifted register (data processing).
- 10 = 12-bit immediate offset (load/store).
- 11 = register offset (load/store).
REQ-024 Data processing, [27:25]=001 or 000, decodes as:
- am = 00 if [27:25]=001, else 01.
- alu_op = [24:21].
- s_bit = [20].
- rf_en = 1, except opcodes 1000–1011 (TST/TEQ/CMP/CMN), which give rf_en = 0.
- load, rw, size, datamem_en, branch_link = 0.
REQ-025 Load/store, [27:25]=010 or 011, decodes as:
- am = 10 if [27:25]=010, else 11.
- datamem_en = 1.
- load = [20] and rf_en = [20].
- rw = ~[20].
- size = [22].
- alu_op = 0100 (ADD) if [23]=1, else 0010 (SUB).
- s_bit = 0.
- branch_link = 0.
REQ-026 Branch, [27:25]=101, decodes as:
- branch_link = 1.
- rf_en = [24] (link writes R14).
- alu_op = 0100.
- All other outputs = 0.
REQ-027 Any other encoding SHALL drive all decode outputs to 0.

Reset
REQ-028 reset=0 SHALL set pc_out to 0x00000000 immediately, asynchronously, including mid-operation; pc_next then reads 0x00000004.
REQ-029 While reset=0, pc_out SHALL remain 0 regardless of pc_le.
REQ-030 When reset releases, the first rising edge with pc_le=1 SHALL produce pc_out=4.

Structure
REQ-031 A shared package SHALL hold the AM encodings (AM_IMM, AM_SHREG, AM_LS_IMM, AM_LS_REG).
REQ-032 The shared package SHALL hold the ALU opcode constants (AND=0000, SUB=0010, ADD=0100, TST..CMN=1000..1011) and the instruction-class field values.
REQ-033 The decoder SHALL be one sub-module, instr_decoder.
REQ-034 The PC register and the +4 adder SHALL reside in the top module.

Verification
REQ-035 reset=0 at t0, released after 3 time units, pc_le=1 -> pc_out sequence 0, 4, 8, 12 on successive rising edges.
REQ-036 pc_le=0 for 2 edges -> pc_out holds; reset pulsed low mid-run -> pc_out=0 without a clock edge.
REQ-037 instruction=0xE2110000 (ANDS) -> am=00, alu_op=0000, s_bit=1, rf_en=1, all others 0.
REQ-038 instruction=0xE7D12000 (LDRB) -> am=11, alu_op=0100, datamem_en=1, rw=0, size=1, load=1, rf_en=1, s_bit=0, branch_link=0.
REQ-039 instruction=0x1AFFFFFD (BNE) -> branch_link=1, rf_en=0, alu_op=0100, all others 0; instruction=0xE2010000 (AND) -> as REQ-037 with s_bit=0.
REQ-040 instruction=0x00000000 -> all decode outputs 0; PC preset to 0xFFFFFFFC -> next edge gives pc_out=0x00000000.
